// File: rtl/mesi_isc_pkg.sv
// mesi_isc_pkg: shared constants and command/state encodings for the MESI inter-cache controller
package mesi_isc_pkg;

    localparam int CPU_NUM = 4;

    typedef enum logic [2:0] {
        MBUS_NOP      = 3'd0,
        MBUS_WR       = 3'd1,
        MBUS_RD       = 3'd2,
        MBUS_WR_BROAD = 3'd3,
        MBUS_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [2:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2,
        CBUS_EN_WR    = 3'd3,
        CBUS_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_ACK    = 2'd3
    } sched_state_e;

    function automatic logic is_req(input logic [2:0] cmd);
        return cmd >= 3'd1 && cmd <= 3'd4;
    endfunction

endpackage

// File: rtl/mesi_isc_bcast_sched_if.sv
// mesi_isc_bcast_sched_if: main-bus requests/acks and coherence-bus commands/acks of the four CPUs
interface mesi_isc_bcast_sched_if #(parameter int ADDR_WIDTH = 32);

    logic [2:0]            mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i;
    logic [ADDR_WIDTH-1:0] mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i;
    logic                  cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i;
    logic [ADDR_WIDTH-1:0] cbus_addr_o;
    logic [2:0]            cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o;
    logic                  mbus_ack3_o, mbus_ack2_o, mbus_ack1_o, mbus_ack0_o;
    logic                  busy_o;

    modport slave (
        input  mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i,
        input  mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i,
        input  cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i,
        output cbus_addr_o,
        output cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o,
        output mbus_ack3_o, mbus_ack2_o, mbus_ack1_o, mbus_ack0_o,
        output busy_o
    );

    modport master (
        output mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i,
        output mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i,
        output cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i,
        input  cbus_addr_o,
        input  cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o,
        input  mbus_ack3_o, mbus_ack2_o, mbus_ack1_o, mbus_ack0_o,
        input  busy_o
    );

endinterface

// File: rtl/mesi_isc_rr_arb.sv
// mesi_isc_rr_arb: 4-way round-robin arbiter, search starts at the pointer and wraps
module mesi_isc_rr_arb
    import mesi_isc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CPU_NUM-1:0] req_i,
    input  logic               upd_i,
    output logic [CPU_NUM-1:0] gnt_o,
    output logic [1:0]         gnt_id_o,
    output logic               vld_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Highest offset first so the lowest offset from the pointer is the last, winning assignment
    always_comb begin
        gnt_id_o = ptr_q;
        vld_o    = 1'b0;
        for (int i = CPU_NUM - 1; i >= 0; i--) begin
            if (req_i[ptr_q + 2'(i)]) begin
                gnt_id_o = ptr_q + 2'(i);
                vld_o    = 1'b1;
            end
        end
        gnt_o = vld_o ? 4'b0001 << gnt_id_o : 4'b0000;
        ptr_d = (upd_i && vld_o) ? gnt_id_o + 2'd1 : ptr_q;
    end

    // Pointer moves just past the CPU that was granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 2'd0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mesi_isc_bcast_sched.sv
// mesi_isc_bcast_sched: grants one CPU transaction at a time and sequences broadcast snoops
module mesi_isc_bcast_sched
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    mesi_isc_bcast_sched_if.slave bus
);

    logic [2:0]            cmd_in  [CPU_NUM];
    logic [ADDR_WIDTH-1:0] addr_in [CPU_NUM];
    logic [CPU_NUM-1:0]    ack_in;
    logic [CPU_NUM-1:0]    req;
    logic [CPU_NUM-1:0]    gnt_oh;
    logic [1:0]            gnt_id;
    logic                  gnt_vld;
    logic [CPU_NUM-1:0]    id_oh;

    sched_state_e          state_q, state_d;
    logic [1:0]            id_q, id_d;
    mbus_cmd_e             rcmd_q, rcmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_NUM-1:0]    mask_q, mask_d;
    logic [CPU_NUM-1:0]    served_q, served_d;
    cbus_cmd_e             ccmd_q [CPU_NUM];
    cbus_cmd_e             ccmd_d [CPU_NUM];
    logic [CPU_NUM-1:0]    mack_q, mack_d;
    logic                  busy_q, busy_d;

    assign cmd_in  = '{bus.mbus_cmd0_i, bus.mbus_cmd1_i, bus.mbus_cmd2_i, bus.mbus_cmd3_i};
    assign addr_in = '{bus.mbus_addr0_i, bus.mbus_addr1_i, bus.mbus_addr2_i, bus.mbus_addr3_i};
    assign ack_in  = {bus.cbus_ack3_i, bus.cbus_ack2_i, bus.cbus_ack1_i, bus.cbus_ack0_i};
    assign id_oh   = 4'b0001 << id_q;

    // A CPU acked last cycle sits out one arbitration so a lingering request is not re-granted
    always_comb begin
        for (int k = 0; k < CPU_NUM; k++) req[k] = is_req(cmd_in[k]) && !served_q[k];
    end

    mesi_isc_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .upd_i    (state_q == ST_IDLE),
        .gnt_o    (gnt_oh),
        .gnt_id_o (gnt_id),
        .vld_o    (gnt_vld)
    );

    // Transaction FSM: grant, snoop the other CPUs, enable the requester, acknowledge
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rcmd_d   = rcmd_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        served_d = '0;
        ccmd_d   = ccmd_q;
        mack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    id_d   = gnt_id;
                    rcmd_d = mbus_cmd_e'(cmd_in[gnt_id]);
                    if (rcmd_d == MBUS_WR_BROAD || rcmd_d == MBUS_RD_BROAD) begin
                        state_d = ST_SNOOP;
                        addr_d  = addr_in[gnt_id];
                        for (int k = 0; k < CPU_NUM; k++)
                            ccmd_d[k] = gnt_oh[k] ? CBUS_NOP :
                                        (rcmd_d == MBUS_WR_BROAD) ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;
                    end else begin
                        state_d        = ST_ACK;
                        mack_d[gnt_id] = 1'b1;
                    end
                end
            end
            ST_SNOOP: begin
                mask_d = mask_q | (ack_in & ~id_oh);
                for (int k = 0; k < CPU_NUM; k++)
                    if (mask_d[k]) ccmd_d[k] = CBUS_NOP;
                if ((mask_d | id_oh) == 4'hF) begin
                    state_d      = ST_ENABLE;
                    mask_d       = '0;
                    ccmd_d[id_q] = (rcmd_q == MBUS_WR_BROAD) ? CBUS_EN_WR : CBUS_EN_RD;
                end
            end
            ST_ENABLE: begin
                if (ack_in[id_q]) begin
                    state_d      = ST_ACK;
                    ccmd_d[id_q] = CBUS_NOP;
                    mack_d[id_q] = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                served_d = id_oh;
            end
        endcase
        busy_d = state_d != ST_IDLE;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            id_q     <= 2'd0;
            rcmd_q   <= MBUS_NOP;
            addr_q   <= '0;
            mask_q   <= '0;
            served_q <= '0;
            ccmd_q   <= '{default: CBUS_NOP};
            mack_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rcmd_q   <= rcmd_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            served_q <= served_d;
            ccmd_q   <= ccmd_d;
            mack_q   <= mack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.cbus_addr_o = addr_q;
    assign bus.cbus_cmd0_o = ccmd_q[0];
    assign bus.cbus_cmd1_o = ccmd_q[1];
    assign bus.cbus_cmd2_o = ccmd_q[2];
    assign bus.cbus_cmd3_o = ccmd_q[3];
    assign bus.mbus_ack0_o = mack_q[0];
    assign bus.mbus_ack1_o = mack_q[1];
    assign bus.mbus_ack2_o = mack_q[2];
    assign bus.mbus_ack3_o = mack_q[3];
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mesi_isc_bcast_sched.sv
// tb_mesi_isc_bcast_sched: directed vectors with hand-computed expectations for the scheduler
module tb_mesi_isc_bcast_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  cmd  [4] = '{default: 3'd0};
    logic [31:0] addr [4] = '{default: 32'd0};
    logic [3:0]  ack = 4'd0;
    logic [3:0]  mack;
    logic [11:0] ccmd;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mesi_isc_bcast_sched_if #(.ADDR_WIDTH(32)) bus ();

    assign bus.mbus_cmd0_i  = cmd[0];
    assign bus.mbus_cmd1_i  = cmd[1];
    assign bus.mbus_cmd2_i  = cmd[2];
    assign bus.mbus_cmd3_i  = cmd[3];
    assign bus.mbus_addr0_i = addr[0];
    assign bus.mbus_addr1_i = addr[1];
    assign bus.mbus_addr2_i = addr[2];
    assign bus.mbus_addr3_i = addr[3];
    assign bus.cbus_ack0_i  = ack[0];
    assign bus.cbus_ack1_i  = ack[1];
    assign bus.cbus_ack2_i  = ack[2];
    assign bus.cbus_ack3_i  = ack[3];
    assign mack = {bus.mbus_ack3_o, bus.mbus_ack2_o, bus.mbus_ack1_o, bus.mbus_ack0_o};
    assign ccmd = {bus.cbus_cmd3_o, bus.cbus_cmd2_o, bus.cbus_cmd1_o, bus.cbus_cmd0_o};

    mesi_isc_bcast_sched #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, ".mack"}, mack, 4'b0000);
        check({tag, ".ccmd"}, ccmd, 12'h000);
        check({tag, ".busy"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        idle_chk("rst");
        check("rst.addr", bus.cbus_addr_o, 32'h0);
        rst = 1'b1;

        // CPU2 RD: ack one cycle after grant, no cbus activity
        cmd[2] = 3'd2; addr[2] = 32'h100;
        tick();
        check("rd2.mack", mack, 4'b0100);
        check("rd2.ccmd", ccmd, 12'h000);
        check("rd2.busy", bus.busy_o, 1'b1);
        cmd[2] = 3'd0;
        tick();
        idle_chk("rd2.done");
        // Pointer now 3: CPU3 beats CPU0
        cmd[0] = 3'd2; cmd[3] = 3'd2;
        tick();
        check("ptr3.mack", mack, 4'b1000);
        cmd[3] = 3'd0;
        tick();
        check("ptr3.gap", mack, 4'b0000);
        tick();
        check("ptr3.cpu0", mack, 4'b0001);
        cmd[0] = 3'd0;
        tick();

        // CPU1 WR_BROAD, zero-wait acks
        cmd[1] = 3'd3; addr[1] = 32'hABCD0000;
        tick();
        check("wb1.snoop", ccmd, 12'b001_001_000_001);
        check("wb1.addr", bus.cbus_addr_o, 32'hABCD0000);
        check("wb1.mack0", mack, 4'b0000);
        check("wb1.busy", bus.busy_o, 1'b1);
        cmd[1] = 3'd0; addr[1] = 32'h0; ack = 4'b1101;
        tick();
        check("wb1.enable", ccmd, 12'b000_000_011_000);
        check("wb1.mack1", mack, 4'b0000);
        ack = 4'b0010;
        tick();
        check("wb1.ack", mack, 4'b0010);
        check("wb1.ackcmd", ccmd, 12'h000);
        check("wb1.addrhold", bus.cbus_addr_o, 32'hABCD0000);
        ack = 4'b0000;
        tick();
        check("wb1.idle", bus.busy_o, 1'b0);

        // All four RD from reset: order 0,1,2,3
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cmd = '{3'd2, 3'd2, 3'd2, 3'd2};
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("all.grant%0d", g), mack, 4'b0001 << g);
            cmd[g] = 3'd0;
            tick();
            check($sformatf("all.gap%0d", g), mack, 4'b0000);
        end

        // CPU0 RD_BROAD, staggered acks, spurious requester ack in SNOOP
        cmd[0] = 3'd4; addr[0] = 32'h2000;
        tick();
        check("rb0.snoop", ccmd, 12'b010_010_010_000);
        check("rb0.addr", bus.cbus_addr_o, 32'h2000);
        cmd[0] = 3'd0; ack = 4'b1001;
        tick();
        check("rb0.e1", ccmd, 12'b000_010_010_000);
        ack = 4'b0100;
        tick();
        check("rb0.e2", ccmd, 12'b000_000_010_000);
        ack = 4'b0000;
        tick();
        check("rb0.e3", ccmd, 12'b000_000_010_000);
        check("rb0.e3busy", bus.busy_o, 1'b1);
        ack = 4'b0010;
        tick();
        check("rb0.enable", ccmd, 12'b000_000_000_100);
        ack = 4'b0100;
        tick();
        check("rb0.e5cmd", ccmd, 12'b000_000_000_100);
        check("rb0.e5mack", mack, 4'b0000);
        ack = 4'b0001;
        tick();
        check("rb0.ack", mack, 4'b0001);
        check("rb0.ackcmd", ccmd, 12'h000);
        ack = 4'b0000;
        tick();
        idle_chk("rb0.done");

        // Reset mid-SNOOP, then ptr-0 ordering (pre-reset ptr would be 3)
        cmd[2] = 3'd3; addr[2] = 32'h5555;
        tick();
        check("mid.snoop", ccmd, 12'b001_000_001_001);
        cmd[2] = 3'd0;
        rst = 1'b0;
        #1;
        idle_chk("mid.rst");
        check("mid.addr", bus.cbus_addr_o, 32'h0);
        tick();
        rst = 1'b1;
        cmd[1] = 3'd2; cmd[3] = 3'd2;
        tick();
        check("mid.cpu1", mack, 4'b0010);
        cmd[1] = 3'd0;
        tick();
        check("mid.gap", mack, 4'b0000);
        tick();
        check("mid.cpu3", mack, 4'b1000);
        cmd[3] = 3'd0;
        tick();

        // CPU1 holds WR past its ack; CPU2 cmd 6 is never a request
        cmd[1] = 3'd1; cmd[2] = 3'd6;
        tick();
        check("hold.ack", mack, 4'b0010);
        tick();
        check("hold.gap", mack, 4'b0000);
        tick();
        idle_chk("hold.noregrant");
        cmd[1] = 3'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            idle_chk($sformatf("hold.cmd6_%0d", c));
        end
        cmd[2] = 3'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
